// File: rtl/veririsc_pkg.sv
// Shared VeriRISC controller definitions: opcode and phase encodings plus ALU-op decode.
package veririsc_pkg;

   localparam int OPCODE_W_DEF = 3;

   localparam logic [OPCODE_W_DEF-1:0] HLT = 3'd0;
   localparam logic [OPCODE_W_DEF-1:0] SKZ = 3'd1;
   localparam logic [OPCODE_W_DEF-1:0] ADD = 3'd2;
   localparam logic [OPCODE_W_DEF-1:0] AND = 3'd3;
   localparam logic [OPCODE_W_DEF-1:0] XOR = 3'd4;
   localparam logic [OPCODE_W_DEF-1:0] LDA = 3'd5;
   localparam logic [OPCODE_W_DEF-1:0] STO = 3'd6;
   localparam logic [OPCODE_W_DEF-1:0] JMP = 3'd7;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_e;

   function automatic logic is_aluop(input logic [OPCODE_W_DEF-1:0] op);
      return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
   endfunction

endpackage

// File: rtl/veririsc_phase_counter.sv
// Phase register, memory wait counter and sticky halt freeze for the VeriRISC sequencer.
module veririsc_phase_counter
   import veririsc_pkg::*;
#(
   parameter int MEM_WAIT = 0
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_halt_req,
   input  logic   i_resume,
   output phase_e o_phase,
   output logic   o_halted
);

   localparam logic [2:0] WAIT_LOAD = 3'(MEM_WAIT);

   phase_e     r_phase;
   logic [2:0] r_wait;
   logic       r_halted;
   phase_e     w_next;
   logic       w_in_fetch;

   // Successor phase in the fixed instruction cycle
   always_comb begin
      w_next = INST_ADDR;
      case (r_phase)
         INST_ADDR:  w_next = INST_FETCH;
         INST_FETCH: w_next = INST_LOAD;
         INST_LOAD:  w_next = IDLE;
         IDLE:       w_next = OP_ADDR;
         OP_ADDR:    w_next = OP_FETCH;
         OP_FETCH:   w_next = ALU_OP;
         ALU_OP:     w_next = STORE;
         STORE:      w_next = INST_ADDR;
         default:    w_next = INST_ADDR;
      endcase
   end

   assign w_in_fetch = (r_phase == INST_FETCH) || (r_phase == OP_FETCH);

   // Sequencer state: halt freeze has priority, then wait countdown, then advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_phase  <= INST_ADDR;
         r_wait   <= 3'd0;
         r_halted <= 1'b0;
      end else if (r_halted) begin
         if (i_resume) begin
            r_halted <= 1'b0;
            r_phase  <= INST_ADDR;
            r_wait   <= 3'd0;
         end else begin
            r_halted <= 1'b1;
         end
      end else if ((r_phase == OP_ADDR) && i_halt_req) begin
         r_halted <= 1'b1;
      end else if (w_in_fetch && (r_wait != 3'd0)) begin
         r_wait <= r_wait - 3'd1;
      end else begin
         r_phase <= w_next;
         // Reload on entry so every fetch gets the full wait count
         if ((w_next == INST_FETCH) || (w_next == OP_FETCH)) begin
            r_wait <= WAIT_LOAD;
         end else begin
            r_wait <= 3'd0;
         end
      end
   end

   assign o_phase  = r_phase;
   assign o_halted = r_halted;

endmodule

// File: rtl/veririsc_controller.sv
// VeriRISC controller: decodes phase and live opcode into datapath strobes.
// Optional resume-from-halt input enabled by defining VERIRISC_CTRL_RESUME_EN.
module veririsc_controller
   import veririsc_pkg::*;
#(
   parameter int OPCODE_W = OPCODE_W_DEF,
   parameter int MEM_WAIT = 0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic                zero,
`ifdef VERIRISC_CTRL_RESUME_EN
   input  logic                resume,
`endif
   output logic                sel,
   output logic                rd,
   output logic                ld_ir,
   output logic                halt,
   output logic                inc_pc,
   output logic                ld_ac,
   output logic                ld_pc,
   output logic                wr,
   output logic                data_e,
   output logic [2:0]          phase
);

   logic [OPCODE_W_DEF-1:0] w_op;
   logic                    w_resume;
   logic                    w_halted;
   logic                    w_alu;
   phase_e                  w_phase;

   assign w_op  = OPCODE_W_DEF'(opcode);
   assign w_alu = is_aluop(w_op);

`ifdef VERIRISC_CTRL_RESUME_EN
   assign w_resume = resume;
`else
   assign w_resume = 1'b0;
`endif

   veririsc_phase_counter #(
      .MEM_WAIT (MEM_WAIT)
   ) u_phase_counter (
      .clk        (clk),
      .rst        (rst),
      .i_halt_req (w_op == HLT),
      .i_resume   (w_resume),
      .o_phase    (w_phase),
      .o_halted   (w_halted)
   );

   assign phase = w_phase;

   // Strobe decode; a halted controller asserts only halt
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      halt   = 1'b0;
      inc_pc = 1'b0;
      ld_ac  = 1'b0;
      ld_pc  = 1'b0;
      wr     = 1'b0;
      data_e = 1'b0;
      if (w_halted) begin
         halt = 1'b1;
      end else begin
         case (w_phase)
            INST_ADDR: sel = 1'b1;
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               inc_pc = 1'b1;
               halt   = (w_op == HLT);
            end
            OP_FETCH: rd = w_alu;
            ALU_OP: begin
               rd     = w_alu;
               inc_pc = (w_op == SKZ) && zero;
               ld_pc  = (w_op == JMP);
               data_e = (w_op == STO);
            end
            STORE: begin
               rd     = w_alu;
               ld_ac  = w_alu;
               ld_pc  = (w_op == JMP);
               inc_pc = (w_op == JMP);
               wr     = (w_op == STO);
               data_e = (w_op == STO);
            end
            default: begin
               sel = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_veririsc_controller.sv
// Directed self-checking bench for veririsc_controller (MEM_WAIT=0 and MEM_WAIT=2 instances).
module tb_veririsc_controller;
   import veririsc_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] opcode = 3'd2;
   logic       zero = 1'b0;
   logic       resume = 1'b0;

   logic sel0, rd0, ld_ir0, halt0, inc_pc0, ld_ac0, ld_pc0, wr0, data_e0;
   logic sel2, rd2, ld_ir2, halt2, inc_pc2, ld_ac2, ld_pc2, wr2, data_e2;
   logic [2:0] ph0, ph2;

   wire [8:0] v0 = {sel0, rd0, ld_ir0, halt0, inc_pc0, ld_ac0, ld_pc0, wr0, data_e0};
   wire [8:0] v2 = {sel2, rd2, ld_ir2, halt2, inc_pc2, ld_ac2, ld_pc2, wr2, data_e2};

   int checks = 0;
   int errors = 0;
   // Expected strobe vector per phase, order {sel,rd,ld_ir,halt,inc_pc,ld_ac,ld_pc,wr,data_e}
   logic [8:0] tbl [8];
   logic [2:0] seq_w2 [12];

   always #5 clk = ~clk;

   veririsc_controller #(.OPCODE_W(3), .MEM_WAIT(0)) dut0 (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
`ifdef VERIRISC_CTRL_RESUME_EN
      .resume(resume),
`endif
      .sel(sel0), .rd(rd0), .ld_ir(ld_ir0), .halt(halt0), .inc_pc(inc_pc0),
      .ld_ac(ld_ac0), .ld_pc(ld_pc0), .wr(wr0), .data_e(data_e0), .phase(ph0)
   );

   veririsc_controller #(.OPCODE_W(3), .MEM_WAIT(2)) dut2 (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero),
`ifdef VERIRISC_CTRL_RESUME_EN
      .resume(resume),
`endif
      .sel(sel2), .rd(rd2), .ld_ir(ld_ir2), .halt(halt2), .inc_pc(inc_pc2),
      .ld_ac(ld_ac2), .ld_pc(ld_pc2), .wr(wr2), .data_e(data_e2), .phase(ph2)
   );

   task automatic load_tbl(input logic [2:0] op, input logic z);
      tbl[0] = 9'b100000000;
      tbl[1] = 9'b110000000;
      tbl[2] = 9'b111000000;
      tbl[3] = 9'b111000000;
      tbl[4] = 9'b000010000;
      tbl[5] = 9'b000000000;
      tbl[6] = 9'b000000000;
      tbl[7] = 9'b000000000;
      case (op)
         3'd0: tbl[4] = 9'b000110000;
         3'd1: tbl[6] = z ? 9'b000010000 : 9'b000000000;
         3'd6: begin
            tbl[6] = 9'b000000001;
            tbl[7] = 9'b000000011;
         end
         3'd7: begin
            tbl[6] = 9'b000000100;
            tbl[7] = 9'b000010100;
         end
         default: begin
            tbl[5] = 9'b010000000;
            tbl[6] = 9'b010000000;
            tbl[7] = 9'b010001000;
         end
      endcase
   endtask

   task automatic start(input logic [2:0] op, input logic z);
      rst = 1'b1;
      resume = 1'b0;
      opcode = op;
      zero = z;
      load_tbl(op, z);
      @(negedge clk);
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (ph0 !== 3'd0 || v0 !== 9'b100000000) begin
         errors++;
         $display("FAIL reset_w0 phase=%0d strobes=%b expected phase=0 strobes=100000000", ph0, v0);
      end
      checks++;
      if (ph2 !== 3'd0 || v2 !== 9'b100000000) begin
         errors++;
         $display("FAIL reset_w2 phase=%0d strobes=%b expected phase=0 strobes=100000000", ph2, v2);
      end
   endtask

   task automatic test_opcode(input logic [2:0] op, input logic z, input int ncyc);
      start(op, z);
      for (int c = 0; c < ncyc; c++) begin
         checks++;
         if (ph0 !== 3'(c % 8) || v0 !== tbl[c % 8]) begin
            errors++;
            $display("FAIL op%0d_z%0d_cyc%0d phase=%0d strobes=%b expected phase=%0d strobes=%b",
                     op, z, c, ph0, v0, c % 8, tbl[c % 8]);
         end
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_halt();
      start(3'd0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (ph0 !== 3'(c) || v0 !== tbl[c]) begin
            errors++;
            $display("FAIL halt_seq_cyc%0d phase=%0d strobes=%b expected phase=%0d strobes=%b",
                     c, ph0, v0, c, tbl[c]);
         end
         @(negedge clk);
         #1;
      end
      for (int c = 0; c < 22; c++) begin
         if (c == 10) opcode = 3'd2;
         checks++;
         if (ph0 !== 3'd4 || v0 !== 9'b000100000) begin
            errors++;
            $display("FAIL halted_cyc%0d phase=%0d strobes=%b expected phase=4 strobes=000100000",
                     c, ph0, v0);
         end
         @(negedge clk);
         #1;
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if (ph0 !== 3'd0 || v0 !== 9'b100000000) begin
         errors++;
         $display("FAIL halt_async_reset phase=%0d strobes=%b expected phase=0 strobes=100000000", ph0, v0);
      end
   endtask

`ifdef VERIRISC_CTRL_RESUME_EN
   task automatic test_resume();
      start(3'd0, 1'b0);
      repeat (12) @(negedge clk);
      #1;
      checks++;
      if (ph0 !== 3'd4 || halt0 !== 1'b1) begin
         errors++;
         $display("FAIL resume_pre phase=%0d halt=%b expected phase=4 halt=1", ph0, halt0);
      end
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      #1;
      checks++;
      if (ph0 !== 3'd0 || v0 !== 9'b100000000) begin
         errors++;
         $display("FAIL resume_post phase=%0d strobes=%b expected phase=0 strobes=100000000", ph0, v0);
      end
      @(negedge clk);
      resume = 1'b1;
      @(negedge clk);
      resume = 1'b0;
      #1;
      checks++;
      if (ph0 !== 3'd2) begin
         errors++;
         $display("FAIL resume_ignored phase=%0d expected 2", ph0);
      end
   endtask
`endif

   task automatic test_mem_wait();
      start(3'd2, 1'b0);
      for (int c = 0; c < 24; c++) begin
         checks++;
         if (ph2 !== seq_w2[c % 12] || v2 !== tbl[seq_w2[c % 12]]) begin
            errors++;
            $display("FAIL wait_cyc%0d phase=%0d strobes=%b expected phase=%0d strobes=%b",
                     c, ph2, v2, seq_w2[c % 12], tbl[seq_w2[c % 12]]);
         end
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset_mid_wait();
      start(3'd2, 1'b0);
      repeat (8) begin
         @(negedge clk);
         #1;
      end
      checks++;
      if (ph2 !== 3'd5) begin
         errors++;
         $display("FAIL midwait_pre phase=%0d expected 5", ph2);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if (ph2 !== 3'd0 || v2 !== 9'b100000000) begin
         errors++;
         $display("FAIL midwait_async phase=%0d strobes=%b expected phase=0 strobes=100000000", ph2, v2);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      for (int c = 0; c < 12; c++) begin
         checks++;
         if (ph2 !== seq_w2[c]) begin
            errors++;
            $display("FAIL midwait_restart_cyc%0d phase=%0d expected %0d", c, ph2, seq_w2[c]);
         end
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      seq_w2 = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd5, 3'd6, 3'd7};
      test_reset();
      test_opcode(3'd2, 1'b0, 16);
      test_opcode(3'd1, 1'b1, 8);
      test_opcode(3'd1, 1'b0, 8);
      test_opcode(3'd6, 1'b0, 8);
      test_opcode(3'd7, 1'b0, 8);
      test_opcode(3'd5, 1'b1, 8);
      test_halt();
`ifdef VERIRISC_CTRL_RESUME_EN
      test_resume();
`endif
      test_mem_wait();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/veririsc_controller.md
Name: veririsc_controller

Overview:
- Phase sequencer for the VeriRISC CPU.
- Steps through an 8-phase instruction cycle and decodes the current IR opcode into datapath control strobes:
  - address-mux select (PC vs IR operand)
  - memory rd/wr
  - IR/AC/PC loads and PC increment
  - data-bus enable
- Adds configurable memory wait states and a sticky halt state.
- Sits between the instruction register / accumulator zero flag and every datapath enable.

Parameters:
- OPCODE_W, 3, opcode width; opcode encodings live in the shared package.
- MEM_WAIT, 0, extra cycles held in INST_FETCH and OP_FETCH for slow memory (0..7).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- opcode  input  OPCODE_W  live IR opcode; valid from INST_LOAD onward
- zero  input  1  accumulator-is-zero flag, live
- sel  output  1  address mux select: 1 = PC, 0 = IR operand address
- rd  output  1  memory read
- ld_ir  output  1  load instruction register
- halt  output  1  processor halted / halting
- inc_pc  output  1  increment PC
- ld_ac  output  1  load accumulator
- ld_pc  output  1  load PC (jump)
- wr  output  1  memory write
- data_e  output  1  drive AC onto data bus
- phase  output  3  current phase, for debug/observability

Behaviour:
- Phases, in order: INST_ADDR=0, INST_FETCH=1, INST_LOAD=2, IDLE=3, OP_ADDR=4, OP_FETCH=5, ALU_OP=6, STORE=7.
- Sequencing:
  - Each phase lasts one cycle, except INST_FETCH and OP_FETCH, which last 1+MEM_WAIT cycles (wait counter reloads on entry).
  - STORE goes to INST_ADDR.
- Registered state: 3-bit phase, wait counter, halted flag. All outputs are combinational from this state plus opcode/zero, so strobes are valid in the same cycle as the phase.
- ALUOP = opcode in {ADD, AND, XOR, LDA}. Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- Decode per phase (unlisted strobes are 0):
  - INST_ADDR: sel.
  - INST_FETCH: sel, rd.
  - INST_LOAD: sel, rd, ld_ir.
  - IDLE: sel, rd, ld_ir.
  - OP_ADDR: inc_pc; halt = (opcode==HLT).
  - OP_FETCH: rd = ALUOP.
  - ALU_OP: rd = ALUOP; inc_pc = (opcode==SKZ && zero); ld_pc = (opcode==JMP); data_e = (opcode==STO).
  - STORE: rd = ALUOP; ld_ac = ALUOP; ld_pc = (opcode==JMP); inc_pc = (opcode==JMP); wr = (opcode==STO); data_e = (opcode==STO).
- Halt:
  - On the OP_ADDR→next edge with opcode==HLT, set halted and freeze phase at OP_ADDR.
  - While halted: halt=1, all other strobes 0 (including inc_pc and sel), phase output reads 4.
  - PC was already incremented once in the halting OP_ADDR cycle.
- Reset:
  - Asynchronous, any phase including mid-wait. Sets phase=INST_ADDR, wait counter=0, halted=0.
  - Outputs during and after reset: sel=1, all others 0, phase=0.
  - The first cycle after deassertion is INST_ADDR.
- opcode/zero changes outside OP_ADDR..STORE have no effect on strobes.
- Opcode is not latched; IR holds it stable from INST_LOAD through STORE.

Optional Feature:
- Macro: VERIRISC_CTRL_RESUME_EN.
- Defined:
  - Adds input port resume (1 bit).
  - While halted, resume=1 on a rising edge clears halted and sets phase=INST_ADDR; execution continues at the already-incremented PC.
  - resume is ignored when not halted.
- Undefined: port absent; halted is cleared only by rst.

Decomposition:
- Shared package veririsc_pkg:
  - opcode localparams HLT..JMP
  - phase localparams INST_ADDR..STORE
  - OPCODE_W default
  - ALU-op membership helper function
- One sub-module is natural: veririsc_phase_counter, holding the phase register, wait counter and halt freeze (with clear, advance and hold controls).
- The controller top holds the strobe decode only.

Test Plan:
- Reset then free run, opcode=ADD, MEM_WAIT=0 → phase 0..7 repeating every 8 cycles. rd high in phases 1,2,3,5,6,7; ld_ac only in phase 7; inc_pc only in phase 4.
- opcode=SKZ, zero=1 → inc_pc high in phases 4 and 6. With zero=0 → inc_pc high in phase 4 only.
- opcode=STO → data_e in phases 6–7, wr only in phase 7, rd never high in phases 5–7. opcode=JMP → ld_pc in phases 6–7, inc_pc in phases 4 and 7.
- opcode=HLT → halt=1 in phase 4, then halt held for 20+ cycles with phase=4 and all other strobes 0. Assert rst → phase=0, sel=1, halt=0 immediately (asynchronous). With VERIRISC_CTRL_RESUME_EN, a 1-cycle resume pulse → phase=0 next cycle.
- MEM_WAIT=2 → INST_FETCH and OP_FETCH each last 3 cycles; full cycle is 12 clocks.
- Assert rst during the second wait cycle of OP_FETCH → outputs reset asynchronously. After release, the sequence restarts at INST_ADDR with a full wait count.
